// File: rtl/dec_pkg.sv
// Shared definitions for the streaming one-hot decoder: code-width helper,
// default counter width and the packed width of one decoded beat.
package dec_pkg;

  localparam int DEFAULT_CNT_W = 8;

  // Smallest width able to hold codes 0..n-1, never less than 1 bit.
  function automatic int clog2_safe(input int n);
    int r;
    r = 1;
    while ((1 << r) < n) r = r + 1;
    return r;
  endfunction

  // A beat is packed as {err, y[n_out-1:0]}.
  function automatic int beat_w(input int n_out);
    return n_out + 1;
  endfunction

endpackage

// File: rtl/onehot_dec.sv
// Combinational binary-to-one-hot decode of a single code.
module onehot_dec
  import dec_pkg::*;
#(
  parameter int OUT = 4,
  parameter int CW  = clog2_safe(OUT)
) (
  input  logic [CW-1:0]  code,
  input  logic           en,
  output logic [OUT-1:0] y,
  output logic           err
);

  // One extra bit so OUT itself is representable when OUT is a power of 2.
  localparam logic [CW:0] OUT_C = (CW+1)'(OUT);

  // Out-of-range codes flag an error and never light a line, whatever en says.
  assign err = ({1'b0, code} >= OUT_C);

  // One comparator per output line.
  generate
    for (genvar gi = 0; gi < OUT; gi++) begin : g_line
      assign y[gi] = en && !err && (code == CW'(gi));
    end
  endgenerate

endmodule

// File: rtl/dec_stream.sv
// Streaming decoder: valid/ready in, registered valid/ready out with a
// one-entry skid buffer, plus sticky seen-mask and saturating transfer count.
module dec_stream
  import dec_pkg::*;
#(
  parameter int OUT   = 4,
  parameter int CW    = clog2_safe(OUT),
  parameter int CNT_W = DEFAULT_CNT_W
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             in_valid,
  output logic             in_ready,
  input  logic [CW-1:0]    in_code,
  input  logic             in_en,
  output logic             out_valid,
  input  logic             out_ready,
  output logic [OUT-1:0]   out_y,
  output logic             out_err,
  input  logic             clr,
  output logic [OUT-1:0]   seen_mask,
  output logic [CNT_W-1:0] txn_cnt
);

  localparam int BW = beat_w(OUT);

  logic [OUT-1:0]   dec_y;
  logic             dec_err;
  logic [BW-1:0]    dec_beat;
  logic             out_valid_reg;
  logic [BW-1:0]    out_beat_reg;
  logic             skid_valid_reg;
  logic [BW-1:0]    skid_beat_reg;
  logic [OUT-1:0]   mask_reg;
  logic [CNT_W-1:0] cnt_reg;
  logic             accept;
  logic             xfer;

  onehot_dec #(
    .OUT (OUT),
    .CW  (CW)
  ) u_dec (
    .code (in_code),
    .en   (in_en),
    .y    (dec_y),
    .err  (dec_err)
  );

  assign dec_beat = {dec_err, dec_y};

  // Ready tracks only the registered skid state; held low while in reset.
  assign in_ready = rst_n & ~skid_valid_reg;
  assign accept   = in_valid & in_ready;
  assign xfer     = out_valid_reg & out_ready;

  // Output stage and skid register: skid fills only when the output is stuck.
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      out_valid_reg  <= 1'b0;
      out_beat_reg   <= '0;
      skid_valid_reg <= 1'b0;
      skid_beat_reg  <= '0;
    end else if (skid_valid_reg) begin
      // in_ready is low here, so only a drain of the skid can happen.
      if (xfer) begin
        out_beat_reg   <= skid_beat_reg;
        skid_valid_reg <= 1'b0;
      end
    end else if (accept) begin
      if (!out_valid_reg || xfer) begin
        out_beat_reg  <= dec_beat;
        out_valid_reg <= 1'b1;
      end else begin
        skid_beat_reg  <= dec_beat;
        skid_valid_reg <= 1'b1;
      end
    end else if (xfer) begin
      out_valid_reg <= 1'b0;
    end
  end

  // Status: clr wins over a concurrent transfer, count saturates at all-ones.
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      mask_reg <= '0;
      cnt_reg  <= '0;
    end else if (clr) begin
      mask_reg <= '0;
      cnt_reg  <= '0;
    end else if (xfer) begin
      mask_reg <= mask_reg | out_beat_reg[OUT-1:0];
      if (cnt_reg != {CNT_W{1'b1}}) cnt_reg <= cnt_reg + CNT_W'(1);
    end
  end

  assign out_valid = out_valid_reg;
  assign out_y     = out_beat_reg[OUT-1:0];
  assign out_err   = out_beat_reg[OUT];
  assign seen_mask = mask_reg;
  assign txn_cnt   = cnt_reg;

endmodule

// File: tb/tb_dec_stream.sv
// Directed bench for dec_stream: a 4-line and a 5-line instance, a vector
// table for single-beat decodes and hand sequences for multi-cycle cases.
module tb_dec_stream;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic rst_n;

  // OUT=4 instance
  logic       iv4, ir4, en4, ov4, or4, err4, clr4;
  logic [1:0] code4;
  logic [3:0] y4, mask4;
  logic [7:0] cnt4;

  // OUT=5 instance
  logic       iv5, ir5, en5, ov5, or5, err5, clr5;
  logic [2:0] code5;
  logic [4:0] y5, mask5;
  logic [7:0] cnt5;

  dec_stream #(.OUT(4), .CNT_W(8)) dut4 (
    .clk(clk), .rst_n(rst_n),
    .in_valid(iv4), .in_ready(ir4), .in_code(code4), .in_en(en4),
    .out_valid(ov4), .out_ready(or4), .out_y(y4), .out_err(err4),
    .clr(clr4), .seen_mask(mask4), .txn_cnt(cnt4)
  );

  dec_stream #(.OUT(5), .CNT_W(8)) dut5 (
    .clk(clk), .rst_n(rst_n),
    .in_valid(iv5), .in_ready(ir5), .in_code(code5), .in_en(en5),
    .out_valid(ov5), .out_ready(or5), .out_y(y5), .out_err(err5),
    .clr(clr5), .seen_mask(mask5), .txn_cnt(cnt5)
  );

  typedef struct {
    logic       sel;     // 0: OUT=4 instance, 1: OUT=5 instance
    logic [2:0] code;
    logic       en;
    logic [4:0] exp_y;
    logic       exp_err;
  } vec_t;

  vec_t tbl [11];

  int vec_cnt  = 0;
  int miss_cnt = 0;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    vec_cnt++;
    if (act !== exp) begin
      miss_cnt++;
      $display("FAIL %s: got %0h expected %0h", name, act, exp);
    end
  endtask

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  initial begin
    logic [7:0] exp_cnt4, exp_cnt5;
    logic [3:0] exp_mask4;
    logic [4:0] exp_mask5;

    tbl[0]  = '{1'b0, 3'd0, 1'b1, 5'b00001, 1'b0};
    tbl[1]  = '{1'b0, 3'd1, 1'b1, 5'b00010, 1'b0};
    tbl[2]  = '{1'b0, 3'd2, 1'b1, 5'b00100, 1'b0};
    tbl[3]  = '{1'b0, 3'd3, 1'b1, 5'b01000, 1'b0};
    tbl[4]  = '{1'b0, 3'd3, 1'b0, 5'b00000, 1'b0};
    tbl[5]  = '{1'b1, 3'd6, 1'b1, 5'b00000, 1'b1};
    tbl[6]  = '{1'b1, 3'd6, 1'b0, 5'b00000, 1'b1};
    tbl[7]  = '{1'b1, 3'd4, 1'b1, 5'b10000, 1'b0};
    tbl[8]  = '{1'b1, 3'd5, 1'b1, 5'b00000, 1'b1};
    tbl[9]  = '{1'b1, 3'd7, 1'b0, 5'b00000, 1'b1};
    tbl[10] = '{1'b1, 3'd0, 1'b1, 5'b00001, 1'b0};

    rst_n = 1'b0;
    iv4 = 0; en4 = 0; code4 = '0; or4 = 1; clr4 = 0;
    iv5 = 0; en5 = 0; code5 = '0; or5 = 1; clr5 = 0;

    // ---- reset ----
    step();
    step();
    check("rst_in_ready", ir4, 0);
    check("rst_out_valid", ov4, 0);
    check("rst_out_y", y4, 0);
    check("rst_out_err", err4, 0);
    check("rst_cnt", cnt4, 0);
    check("rst_mask", mask4, 0);
    rst_n = 1'b1;
    #1;
    check("post_rst_in_ready", ir4, 1);

    // ---- table vectors, streaming with out_ready=1 ----
    exp_cnt4 = 0; exp_cnt5 = 0; exp_mask4 = 0; exp_mask5 = 0;
    for (int i = 0; i < 11; i++) begin
      if (tbl[i].sel == 1'b0) begin
        iv4 = 1; code4 = tbl[i].code[1:0]; en4 = tbl[i].en; iv5 = 0;
        exp_cnt4 = exp_cnt4 + 1;
        exp_mask4 = exp_mask4 | tbl[i].exp_y[3:0];
      end else begin
        iv4 = 0; iv5 = 1; code5 = tbl[i].code; en5 = tbl[i].en;
        exp_cnt5 = exp_cnt5 + 1;
        exp_mask5 = exp_mask5 | tbl[i].exp_y;
      end
      step();
      if (tbl[i].sel == 1'b0) begin
        check("vec_valid4", ov4, 1);
        check("vec_y4", y4, {1'b0, tbl[i].exp_y[3:0]});
        check("vec_err4", err4, tbl[i].exp_err);
        check("vec_ready4", ir4, 1);
        $display("vec %0d: dut4 code=%0d en=%0d y=%b err=%0d", i, tbl[i].code, tbl[i].en, y4, err4);
      end else begin
        check("vec_valid5", ov5, 1);
        check("vec_y5", y5, tbl[i].exp_y);
        check("vec_err5", err5, tbl[i].exp_err);
        check("vec_ready5", ir5, 1);
        $display("vec %0d: dut5 code=%0d en=%0d y=%b err=%0d", i, tbl[i].code, tbl[i].en, y5, err5);
      end
    end
    iv4 = 0; iv5 = 0;
    step();
    check("tbl_drain_valid4", ov4, 0);
    check("tbl_drain_valid5", ov5, 0);
    check("tbl_cnt4", cnt4, exp_cnt4);
    check("tbl_mask4", mask4, exp_mask4);
    check("tbl_cnt5", cnt5, exp_cnt5);
    check("tbl_mask5", mask5, exp_mask5);

    // ---- backpressure and skid ----
    or4 = 0; iv4 = 1; en4 = 1; code4 = 2'd2;
    step();
    check("bp_first_y", y4, 4'b0100);
    check("bp_first_ready", ir4, 1);
    code4 = 2'd1;
    step();
    check("bp_hold_y", y4, 4'b0100);
    check("bp_skid_ready", ir4, 0);
    code4 = 2'd3;
    step();
    check("bp_third_held_y", y4, 4'b0100);
    check("bp_third_ready", ir4, 0);
    check("bp_cnt_frozen", cnt4, exp_cnt4);
    or4 = 1;
    step();
    check("bp_skid_out_y", y4, 4'b0010);
    check("bp_ready_back", ir4, 1);
    step();
    check("bp_third_y", y4, 4'b1000);
    check("bp_third_valid", ov4, 1);
    iv4 = 0;
    step();
    check("bp_drain_valid", ov4, 0);
    check("bp_cnt", cnt4, exp_cnt4 + 3);
    $display("backpressure: cnt=%0d mask=%b", cnt4, mask4);

    // ---- saturation and clr ----
    iv4 = 1; code4 = 2'd0; en4 = 1;
    for (int k = 0; k < 300; k++) step();
    check("sat_cnt", cnt4, 8'd255);
    clr4 = 1;
    step();
    clr4 = 0;
    check("clr_cnt", cnt4, 0);
    check("clr_mask", mask4, 0);
    check("clr_valid", ov4, 1);
    step();
    check("post_clr_cnt", cnt4, 1);
    check("post_clr_mask", mask4, 4'b0001);
    iv4 = 0;
    step();
    check("post_clr_drain_cnt", cnt4, 2);
    check("post_clr_drain_valid", ov4, 0);
    $display("saturation/clr: cnt=%0d mask=%b", cnt4, mask4);

    // ---- reset with output and skid both full ----
    or4 = 0; iv4 = 1; code4 = 2'd1;
    step();
    code4 = 2'd2;
    step();
    iv4 = 0;
    check("prerst_ready", ir4, 0);
    check("prerst_valid", ov4, 1);
    rst_n = 0;
    #1;
    check("inrst_ready_comb", ir4, 0);
    step();
    check("inrst_valid", ov4, 0);
    check("inrst_ready", ir4, 0);
    check("inrst_cnt", cnt4, 0);
    rst_n = 1;
    #1;
    check("rel_ready", ir4, 1);
    or4 = 1;
    step();
    check("no_stale_valid_a", ov4, 0);
    step();
    check("no_stale_valid_b", ov4, 0);
    check("no_stale_y", y4, 0);
    iv4 = 1; code4 = 2'd3; en4 = 1;
    step();
    check("after_rst_y", y4, 4'b1000);
    check("after_rst_valid", ov4, 1);
    iv4 = 0;
    step();
    check("after_rst_cnt", cnt4, 1);
    check("after_rst_mask", mask4, 4'b1000);
    $display("reset mid-flight: cnt=%0d mask=%b", cnt4, mask4);

    $display("== %0d vectors applied, %0d miscompares ==", vec_cnt, miss_cnt);
    $finish;
  end

endmodule

// File: doc/dec_stream.md
Name: dec_stream

Overview:
- Streaming binary-to-one-hot decoder. It is the inverse of the team's 4-to-2 one-hot encoder and sits on the consumer side of the encoded bus.
- Input and output are each a valid/ready handshake. The output stage is registered and backed by a 1-entry skid buffer, so throughput is one code per cycle under backpressure.
- Keeps a sticky mask of every line decoded and a saturating transaction counter, both for debug and status readback.

Parameters:
- OUT, 4, number of one-hot output lines (>=2).
- CW, $clog2(OUT), code width (derived; do not override).
- CNT_W, 8, transaction counter width.

Ports:
- clk  input  1  single clock, rising edge.
- rst_n  input  1  synchronous reset, active-low.
- in_valid  input  1  upstream code valid.
- in_ready  output  1  block can accept a code.
- in_code  input  CW  binary code.
- in_en  input  1  decode enable, sampled with the code; 0 means the beat decodes to all-zeros.
- out_valid  output  1  decoded beat valid.
- out_ready  input  1  downstream accepts.
- out_y  output  OUT  one-hot result.
- out_err  output  1  beat carried code >= OUT (only possible when OUT is not a power of 2).
- clr  input  1  synchronous clear of seen_mask and txn_cnt.
- seen_mask  output  OUT  OR of every out_y transferred since reset/clr.
- txn_cnt  output  CNT_W  count of output transfers, saturating.

Behaviour:
- Reset: synchronous, active-low, applied on a clk edge with rst_n=0. Reset has priority over every other event.
- Reset values: out_valid=0, out_y=0, out_err=0, seen_mask=0, txn_cnt=0, skid empty.
- in_ready is forced to 0 while rst_n=0. It is 1 in the first cycle after rst_n rises.
- Accept rule: a beat is accepted on an edge where in_valid && in_ready.
- Decode rule:
  - in_en=1 and in_code<OUT: y[in_code]=1, all other bits 0, err=0.
  - in_code>=OUT: y=0, err=1, regardless of in_en.
  - in_en=0 and in_code<OUT: y=0, err=0.
- Latency: a beat accepted at edge N is on out_y/out_valid from edge N until its transfer (out_valid && out_ready). There is no bubble when the output is empty.
- Output hold: while out_valid && !out_ready, out_y and out_err are stable.
- Skid buffer:
  - If a beat is accepted while the output stage is occupied and not transferring, the beat goes to the skid register and in_ready=0 from the next cycle.
  - On the next output transfer, skid moves to the output stage and in_ready returns to 1 the following cycle.
  - in_ready depends only on skid occupancy (registered). There is no combinational in_ready<-out_ready path.
- Simultaneous events:
  - Accept + output transfer with skid empty: new beat loads the output stage directly; out_valid stays 1.
  - Accept + transfer with skid full: cannot occur, because in_ready=0.
- Ordering: strict FIFO order. No beat is dropped or duplicated.
- Status, on each output transfer:
  - seen_mask |= out_y.
  - txn_cnt += 1, saturating at 2^CNT_W-1 with no wrap.
  - err beats count toward txn_cnt.
- clr:
  - Has priority over a concurrent transfer: the result is mask=0 and cnt=0, and that transfer is not counted.
  - Does not affect the datapath or handshake.
- Reset mid-operation: in-flight output and skid contents are discarded. No out_valid is asserted for them afterwards.

Decomposition:
- Shared package dec_pkg holds:
  - code-width function clog2_safe (returns >=1);
  - default CNT_W constant;
  - a beat struct {y[OUT], err} typedef, or an equivalent packed-width constant.
- One natural sub-module: onehot_dec, purely combinational (in_code, in_en -> y, err), instantiated once ahead of the registers.
- Skid and output registers, status logic and handshake stay in dec_stream.

Test Plan:
- Reset, then codes 0,1,2,3 back-to-back with in_en=1 and out_ready=1 -> out_y=0001,0010,0100,1000 on consecutive cycles after the first edge; in_ready stays 1; txn_cnt=4; seen_mask=1111.
- Hold out_ready=0, feed codes 2 then 1 -> out_y=0100 held; in_ready=0 after the second accept; third beat not accepted; on out_ready=1 -> 0100 then 0010, in_ready=1 again.
- in_en=0 with code 3 -> out_y=0000, out_err=0, txn_cnt increments, seen_mask unchanged. With OUT=5, code 6 -> out_y=00000, out_err=1.
- Issue 300 transfers with CNT_W=8 -> txn_cnt saturates at 255. clr asserted on the same edge as a transfer -> txn_cnt=0 and seen_mask=0 next cycle.
- Drop rst_n for one edge while output and skid both hold beats -> out_valid=0, in_ready=0 during reset; in_ready=1 the cycle after release; no stale beat ever appears on out_y.
